// File: rtl/cache_req_queue.sv
// cache_req_queue: buffers CPU cache requests in a small FIFO and issues them
// one at a time to a cache controller. Each request is held on the controller
// port for HOLD_CYCLES cycles, then the controller result goes back to the CPU.
// Optional macro CACHE_REQ_QUEUE_POSTED_WR_EN: when defined, writes are posted
// and complete without a CPU response.

module cache_req_queue #(
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  // CPU request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [WORD_SIZE-1:0]   req_addr,
  input  logic [WORD_SIZE-1:0]   req_data,
  // CPU response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_data,
  output logic                   rsp_wr,
  // cache controller side
  output logic                   ctl_wr_en,
  output logic [WORD_SIZE-1:0]   ctl_addr,
  output logic [WORD_SIZE-1:0]   ctl_data,
  input  logic [WORD_SIZE-1:0]   ctl_data_out,
  // status
  output logic                   busy,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int EW = 2 * WORD_SIZE + 1;

  localparam logic [AW:0]   OCC_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage: {wr, addr, data} per entry, no reset so it maps onto RAM
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [HW-1:0] hold_cnt;
  logic          issue_wr;
  logic          push;
  logic          pop;
  logic          capture;

  // Ready depends only on the registered count, so a full queue never accepts
  // even when the FSM is popping in the same cycle.
  assign req_ready = (occupancy < OCC_FULL);
  assign push      = req_valid && req_ready;

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign ctl_wr_en = (state == ISSUE) && issue_wr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: pop when idle, hold the request, then present the result
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (occupancy != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (hold_cnt == HOLD_LAST) begin
`ifdef CACHE_REQ_QUEUE_POSTED_WR_EN
          if (issue_wr) begin
            state_next = IDLE;
          end else begin
            capture    = 1'b1;
            state_next = RESP;
          end
`else
          capture    = 1'b1;
          state_next = RESP;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO write port: accepted requests land at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {req_wr, req_addr, req_data};
    end
  end

  // Pointers, count, issue registers, hold counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      hold_cnt  <= '0;
      issue_wr  <= 1'b0;
      ctl_addr  <= '0;
      ctl_data  <= '0;
      rsp_data  <= '0;
      rsp_wr    <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head                          <= head + PTR_ONE;
        {issue_wr, ctl_addr, ctl_data} <= mem[head];
        hold_cnt                      <= '0;
      end else if (state == ISSUE) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
      if (capture) begin
        rsp_data <= ctl_data_out;
        rsp_wr   <= issue_wr;
      end
    end
  end

endmodule

// File: tb/tb_cache_req_queue.sv
// Testbench for cache_req_queue: directed stimulus with a response scoreboard.
// The controller is modelled as returning {16'hCAFE, ctl_addr[15:0]}.

module tb_cache_req_queue;

  localparam int W = 32;
`ifdef CACHE_REQ_QUEUE_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_wr;
  logic         ctl_wr_en;
  logic [W-1:0] ctl_addr;
  logic [W-1:0] ctl_data;
  logic [W-1:0] ctl_data_out;
  logic         busy;
  logic [2:0]   occupancy;

  cache_req_queue #(.WORD_SIZE(W), .DEPTH(4), .HOLD_CYCLES(6)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_wr(rsp_wr),
    .ctl_wr_en(ctl_wr_en),
    .ctl_addr(ctl_addr),
    .ctl_data(ctl_data),
    .ctl_data_out(ctl_data_out),
    .busy(busy),
    .occupancy(occupancy)
  );

  assign ctl_data_out = {16'hCAFE, ctl_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int resp_count = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: compare every response handshake against the scoreboard and
  // check response stability while stalled.
  logic       prev_stall;
  logic [W:0] prev_rsp;
  logic [W:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("rsp_ctl_wr_en_low", ctl_wr_en, 0);
        if (prev_stall) check("rsp_stable", {rsp_wr, rsp_data}, prev_rsp);
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_exp[W-1:0]);
          check("rsp_wr", rsp_wr, mon_exp[W]);
          $display("rsp: data=%08h wr=%0d", rsp_data, rsp_wr);
        end
        resp_count++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_wr, rsp_data};
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] data,
                          input logic exp_rsp, input logic [W-1:0] exp_data);
    int waited = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept_in_time", waited < 200, 1);
    @(posedge clk);
    if (exp_rsp) exp_q.push_back({wr, exp_data});
    $display("req: wr=%0d addr=%08h data=%08h", wr, addr, data);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || occupancy != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] t3_addr [6];
  logic [W-1:0] t3_exp  [6];

  initial begin
    int lat;
    int cnt;
    int match;
    int base;
    t3_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    t3_exp  = '{32'hCAFE0000, 32'hCAFE0004, 32'hCAFE0008,
                32'hCAFE000C, 32'hCAFE0010, 32'hCAFE0014};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_ctl_wr_en", ctl_wr_en, 0);
    check("rst_ctl_addr", ctl_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("first_cycle_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // single read of 0x40: latency and data
    rsp_ready = 1'b1;
    push_req(1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFE0040);
    @(negedge clk);
    check("pop_cycle_busy", busy, 0);
    check("pop_cycle_occupancy", occupancy, 1);
    lat = 0; cnt = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (ctl_wr_en) cnt++;
      if (lat == 1) check("read_ctl_addr", ctl_addr, 32'h40);
    end
    check("read_latency", lat, 7);
    check("read_no_wr_en", cnt, 0);
    drain("drain_single_read");

    // fill to full behind a stalled response, hold a 5th request
    rsp_ready = 1'b0;
    push_req(1'b0, 32'h100, 32'h0, 1'b1, 32'hCAFE0100);
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("stall_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    push_req(1'b0, 32'h104, 32'h0, 1'b1, 32'hCAFE0104);
    push_req(1'b0, 32'h108, 32'h0, 1'b1, 32'hCAFE0108);
    push_req(1'b0, 32'h10C, 32'h0, 1'b1, 32'hCAFE010C);
    push_req(1'b0, 32'h110, 32'h0, 1'b1, 32'hCAFE0110);
    @(negedge clk);
    check("full_occupancy", occupancy, 4);
    check("full_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h114; req_data = 32'h0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid && !req_ready && occupancy == 4) cnt++;
    end
    check("resp_hold_10_cycles", cnt, 10);
    @(posedge clk); #1 rsp_ready = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!req_ready && cnt < 50);
    check("full_pop_no_push_wait", cnt, 3);
    @(posedge clk);
    exp_q.push_back({1'b0, 32'hCAFE0114});
    $display("req: wr=0 addr=%08h data=%08h", 32'h114, 32'h0);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("refill_occupancy", occupancy, 4);
    drain("drain_full");

    // six reads while draining: order and pointer wrap
    base = resp_count;
    for (int i = 0; i < 6; i++) push_req(1'b0, t3_addr[i], 32'h0, 1'b1, t3_exp[i]);
    drain("drain_wrap");
    check("wrap_rsp_count", resp_count - base, 6);

    // reset in ISSUE at hold_cnt 3 with two entries queued
    push_req(1'b0, 32'h200, 32'h0, 1'b1, 32'hCAFE0200);
    push_req(1'b0, 32'h204, 32'h0, 1'b1, 32'hCAFE0204);
    push_req(1'b0, 32'h208, 32'h0, 1'b1, 32'hCAFE0208);
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_occupancy", occupancy, 2);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ctl_addr", ctl_addr, 32'h200);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_ctl_wr_en", ctl_wr_en, 0);
    check("async_rst_ctl_addr", ctl_addr, 0);
    check("async_rst_ctl_data", ctl_data, 0);
    check("async_rst_rsp_data", rsp_data, 0);
    check("async_rst_rsp_wr", rsp_wr, 0);
    check("async_rst_occupancy", occupancy, 0);
    exp_q.delete();
    base = resp_count;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    repeat (30) @(negedge clk);
    check("post_rst_no_response", resp_count - base, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // write of 0x1234 to 0x80
    push_req(1'b1, 32'h80, 32'h1234, !POSTED, 32'hCAFE0080);
    cnt = 0; match = 0;
    repeat (30) begin
      @(negedge clk);
      if (ctl_wr_en) cnt++;
      if (ctl_wr_en && ctl_addr == 32'h80 && ctl_data == 32'h1234) match++;
    end
    check("write_wr_en_cycles", cnt, 6);
    check("write_ctl_addr_data", match, 6);
    drain("drain_write");
    check("total_responses", resp_count, POSTED ? 13 : 14);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_req_queue.md
CACHE_REQ_QUEUE -- requirements
Module: cache_req_queue

Interface
REQ-001 Parameter WORD_SIZE, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 4, request FIFO entries; power of two, at least 2.
REQ-003 Parameter HOLD_CYCLES, default 6, cycles each request is driven to the cache controller; at least 2.
REQ-004 Ports: clk, input, 1 bit, clock; rst, input, 1 bit, reset, asynchronous, active-high.
REQ-005 Ports: req_valid in 1; req_ready out 1; req_wr in 1; req_addr in WORD_SIZE; req_data in WORD_SIZE. These form the CPU request channel.
REQ-006 Ports: rsp_valid out 1; rsp_ready in 1; rsp_data out WORD_SIZE; rsp_wr out 1. These form the CPU response channel.
REQ-007 Ports: ctl_wr_en out 1; ctl_addr out WORD_SIZE; ctl_data out WORD_SIZE; ctl_data_out in WORD_SIZE. These are the controller-side request and result.
REQ-008 Ports: busy out 1, meaning the FSM is not IDLE; occupancy out clog2(DEPTH)+1, meaning the FIFO entry count.

Function
REQ-009 A request SHALL be accepted on a rising edge with req_valid and req_ready both high.
- The accepted {req_wr, req_addr, req_data} is written at the tail.
- The tail pointer increments modulo DEPTH.
REQ-010 req_ready SHALL equal (occupancy < DEPTH), derived from registered state only.
- When full, no push occurs, even in a cycle where a pop also occurs.
REQ-011 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-012 IDLE with occupancy > 0 SHALL pop the head into issue registers on the next edge, clear hold_cnt to 0 and enter ISSUE.
- The head pointer wraps modulo DEPTH.
REQ-013 A simultaneous push and pop SHALL leave occupancy unchanged and keep both entries intact.
REQ-014 In ISSUE, ctl_addr, ctl_data and ctl_wr_en SHALL be driven from the issue registers, held stable every cycle of ISSUE.
REQ-015 In ISSUE, hold_cnt SHALL increment each cycle.
- On the edge where hold_cnt == HOLD_CYCLES-1, ctl_data_out is captured into rsp_data.
- rsp_wr is set to the request's wr flag.
- The FSM enters RESP.
REQ-016 In RESP, rsp_valid SHALL be high; the edge with rsp_ready high SHALL drop rsp_valid and return to IDLE.
REQ-017 rsp_data and rsp_wr SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-018 In IDLE and RESP, ctl_wr_en SHALL be 0 and ctl_addr and ctl_data SHALL hold their last values.
REQ-019 Responses SHALL return in request order; at most one request SHALL be in flight.
REQ-020 Latency from pop to rsp_valid SHALL be exactly HOLD_CYCLES+1 cycles.

Reset
REQ-021 Asserting rst SHALL immediately clear the following:
- pointers, occupancy, hold_cnt;
- FSM to IDLE;
- rsp_valid, rsp_wr, rsp_data, ctl_wr_en, ctl_addr, ctl_data to 0;
- busy to 0.
REQ-022 A reset asserted during ISSUE or RESP SHALL discard the in-flight request and all queued entries; no response SHALL be produced for them.
REQ-023 After rst deasserts, req_ready SHALL be 1 on the first cycle.

Configuration
REQ-024 Macro CACHE_REQ_QUEUE_POSTED_WR_EN SHALL select write-response behaviour.
- Defined: a write leaves ISSUE directly to IDLE at hold_cnt == HOLD_CYCLES-1, with no response, and rsp_valid is never asserted for writes.
- Undefined: writes produce a response with rsp_wr = 1 and rsp_data = the captured ctl_data_out.

Verification
REQ-025 Single read of addr 0x40, with ctl_data_out modelled as 0xCAFE0040 -> rsp_valid 7 cycles after pop, rsp_data = 0xCAFE0040, rsp_wr = 0.
REQ-026 Push 4 requests with rsp_ready = 0 -> occupancy reaches 4 and req_ready = 0; with a 5th req_valid held, no push occurs until the first pop.
REQ-027 Push 6 reads to addrs 0x0..0x14 while draining -> responses arrive in order and the pointers wrap with no loss or duplication.
REQ-028 rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_data stay constant, and ctl_wr_en stays 0.
REQ-029 rst pulsed at hold_cnt = 3 with 2 entries queued -> all outputs are 0 that cycle, occupancy = 0, and no response appears afterwards.
REQ-030 Write to 0x80 with data 0x1234 -> ctl_wr_en = 1 for exactly 6 cycles; response is present only when CACHE_REQ_QUEUE_POSTED_WR_EN is undefined.
